spi_frame_loader: RTL and testbench

SPI_FRAME_LOADER -- requirements
Module: spi_frame_loader

---
 rtl/spi_frame_loader_pkg.sv | 27 ++
 rtl/spi_frame_loader_if.sv | 27 ++
 rtl/spi_frame_loader.sv | 180 ++++++++++++++++++
 tb/tb_spi_frame_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_loader_pkg.sv
// Shared definitions for the SPI frame loader: command codes, FSM states
// and the default frame-buffer geometry (160 LEDs x 3 colour channels).
package spi_frame_loader_pkg;

   localparam int unsigned DEFAULT_ADDRESS_WIDTH = 13;
   localparam int unsigned DEFAULT_MEM_SIZE      = 480;

   localparam logic [7:0] CMD_WRITE  = 8'h01;
   localparam logic [7:0] CMD_READ   = 8'h02;
   localparam logic [7:0] CMD_COMMIT = 8'h03;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR_HI,
      ADDR_LO,
      WRITE_DATA,
      READ_DATA,
      DISCARD
   } state_t;

   typedef enum logic {
      OP_WRITE,
      OP_READ
   } op_t;

endpackage

// File: rtl/spi_frame_loader_if.sv
// Bundle of the SPI byte-stream handshake and the frame-buffer BRAM port.
// The loader sits on the slave side; the SPI core plus BRAM sit on the master side.
interface spi_frame_loader_if
   import spi_frame_loader_pkg::*;
#(
   parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
);
   logic                     spi_selected;
   logic                     spi_done;
   logic [7:0]               spi_dout;
   logic [7:0]               spi_din;
   logic                     mem_we;
   logic [ADDRESS_WIDTH-1:0] mem_addr;
   logic [7:0]               mem_din;
   logic [7:0]               mem_dout;

   modport slave (
      input  spi_selected, spi_done, spi_dout, mem_dout,
      output spi_din, mem_we, mem_addr, mem_din
   );

   modport master (
      output spi_selected, spi_done, spi_dout, mem_dout,
      input  spi_din, mem_we, mem_addr, mem_din
   );

endinterface

// File: rtl/spi_frame_loader.sv
// SPI frame loader: decodes a command/address header from an SPI byte stream
// and then streams bytes into (write) or out of (read) the LED frame buffer.
// A commit command pulses frame_ready and bumps the frame counter.
module spi_frame_loader
   import spi_frame_loader_pkg::*;
#(
   parameter int          ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
   parameter int unsigned MEM_SIZE      = DEFAULT_MEM_SIZE
)(
   input  logic               clk,
   input  logic               rst_n,
   spi_frame_loader_if.slave  bus,
   output logic               frame_ready,
   output logic [7:0]         frame_count,
   output logic               addr_error
);

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEM_SIZE - 1);

   state_t                   state_q, state_d;
   op_t                      op_q, op_d;
   logic [7:0]               addr_hi_q, addr_hi_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]               spi_din_q, spi_din_d;
   logic                     mem_we_q, mem_we_d;
   logic [7:0]               mem_din_q, mem_din_d;
   logic                     frame_ready_q, frame_ready_d;
   logic [7:0]               frame_count_q, frame_count_d;
   logic                     addr_error_q, addr_error_d;
   logic                     fetch_wait_q, fetch_wait_d;
   logic                     fetch_latch_q, fetch_latch_d;

   logic                     byte_ok;
   logic [15:0]              header_addr;

   // A byte only counts while the slave is actually selected.
   assign byte_ok     = bus.spi_done & bus.spi_selected;
   assign header_addr = {addr_hi_q, bus.spi_dout};

   function automatic logic [ADDRESS_WIDTH-1:0] wrap_inc(input logic [ADDRESS_WIDTH-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + ADDRESS_WIDTH'(1);
   endfunction

   // Next-state and next-register values; read prefetch runs as a two-stage
   // pipeline (address settles, then BRAM data is captured into spi_din).
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_hi_d     = addr_hi_q;
      addr_d        = addr_q;
      spi_din_d     = spi_din_q;
      mem_we_d      = 1'b0;
      mem_din_d     = mem_din_q;
      frame_ready_d = 1'b0;
      frame_count_d = frame_count_q;
      addr_error_d  = addr_error_q;
      fetch_wait_d  = 1'b0;
      fetch_latch_d = fetch_wait_q;

      if (mem_we_q) begin
         addr_d = wrap_inc(addr_q);
      end

      case (state_q)
         IDLE, CMD: begin
            if (byte_ok) begin
               case (bus.spi_dout)
                  CMD_WRITE: begin
                     op_d    = OP_WRITE;
                     state_d = ADDR_HI;
                  end
                  CMD_READ: begin
                     op_d    = OP_READ;
                     state_d = ADDR_HI;
                  end
                  CMD_COMMIT: begin
                     state_d       = DISCARD;
                     frame_ready_d = 1'b1;
                     frame_count_d = frame_count_q + 8'd1;
                  end
                  default: state_d = DISCARD;
               endcase
            end else if (state_q == IDLE) begin
               state_d = CMD;
            end
         end
         ADDR_HI: begin
            if (byte_ok) begin
               addr_hi_d = bus.spi_dout;
               state_d   = ADDR_LO;
            end
         end
         ADDR_LO: begin
            if (byte_ok) begin
               if (32'(header_addr) >= MEM_SIZE) begin
                  addr_error_d = 1'b1;
                  state_d      = DISCARD;
               end else begin
                  addr_d = ADDRESS_WIDTH'(header_addr);
                  if (op_q == OP_READ) begin
                     state_d      = READ_DATA;
                     fetch_wait_d = 1'b1;
                  end else begin
                     state_d = WRITE_DATA;
                  end
               end
            end
         end
         WRITE_DATA: begin
            if (byte_ok) begin
               mem_we_d  = 1'b1;
               mem_din_d = bus.spi_dout;
            end
         end
         READ_DATA: begin
            if (byte_ok) begin
               addr_d       = wrap_inc(addr_q);
               fetch_wait_d = 1'b1;
            end
         end
         DISCARD: begin
         end
         default: state_d = IDLE;
      endcase

      if (!bus.spi_selected) begin
         state_d      = IDLE;
         mem_we_d     = 1'b0;
         fetch_wait_d = 1'b0;
      end

      if (state_d == READ_DATA) begin
         if (fetch_latch_q) begin
            spi_din_d = bus.mem_dout;
         end
      end else begin
         spi_din_d = 8'h00;
      end
   end

   // State and datapath registers, cleared immediately when rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         op_q          <= OP_WRITE;
         addr_hi_q     <= 8'h00;
         addr_q        <= '0;
         spi_din_q     <= 8'h00;
         mem_we_q      <= 1'b0;
         mem_din_q     <= 8'h00;
         frame_ready_q <= 1'b0;
         frame_count_q <= 8'h00;
         addr_error_q  <= 1'b0;
         fetch_wait_q  <= 1'b0;
         fetch_latch_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         addr_hi_q     <= addr_hi_d;
         addr_q        <= addr_d;
         spi_din_q     <= spi_din_d;
         mem_we_q      <= mem_we_d;
         mem_din_q     <= mem_din_d;
         frame_ready_q <= frame_ready_d;
         frame_count_q <= frame_count_d;
         addr_error_q  <= addr_error_d;
         fetch_wait_q  <= fetch_wait_d;
         fetch_latch_q <= fetch_latch_d;
      end
   end

   assign bus.spi_din  = spi_din_q;
   assign bus.mem_we   = mem_we_q;
   assign bus.mem_addr = addr_q;
   assign bus.mem_din  = mem_din_q;
   assign frame_ready  = frame_ready_q;
   assign frame_count  = frame_count_q;
   assign addr_error   = addr_error_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Self-checking bench for spi_frame_loader: a table of write transactions
// plus hand-written read, commit, back-to-back and reset sequences.
module tb_spi_frame_loader;

   localparam int AW = 13;

   logic       clk;
   logic       rst_n;
   logic       frame_ready;
   logic [7:0] frame_count;
   logic       addr_error;

   logic          preload_en;
   logic [AW-1:0] preload_addr;
   logic [7:0]    preload_data;

   logic [7:0]    mem [0:(1<<AW)-1];
   logic [AW-1:0] wrAddrQ[$];
   logic [7:0]    wrDataQ[$];
   int            frameReadyCycles;

   int checks;
   int failures;

   typedef struct {
      int          nBytes;
      logic [39:0] bytes;
      int          expWrites;
      logic [12:0] expAddr0;
      logic [7:0]  expData0;
      logic [12:0] expAddr1;
      logic [7:0]  expData1;
      logic        expErr;
   } vec_t;

   vec_t vecs[6];

   spi_frame_loader_if #(.ADDRESS_WIDTH(AW)) bus();

   spi_frame_loader #(.ADDRESS_WIDTH(AW), .MEM_SIZE(480)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .frame_ready (frame_ready),
      .frame_count (frame_count),
      .addr_error  (addr_error)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous-read BRAM model with a bench-side preload port
   always @(posedge clk) begin
      if (preload_en) begin
         mem[preload_addr] <= preload_data;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_din;
      end
      bus.mem_dout <= mem[bus.mem_addr];
   end

   // Log every cycle that mem_we is high, and count frame_ready cycles
   initial begin
      frameReadyCycles = 0;
      forever begin
         @(negedge clk);
         if (bus.mem_we === 1'b1) begin
            wrAddrQ.push_back(bus.mem_addr);
            wrDataQ.push_back(bus.mem_din);
         end
         if (frame_ready === 1'b1) frameReadyCycles++;
      end
   end

   // Hard stop in case the stimulus ever stalls
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, " spi_din"},     32'(bus.spi_din),   32'h00);
      checkOutput({tag, " mem_we"},      32'(bus.mem_we),    32'h0);
      checkOutput({tag, " mem_addr"},    32'(bus.mem_addr),  32'h0);
      checkOutput({tag, " mem_din"},     32'(bus.mem_din),   32'h00);
      checkOutput({tag, " frame_ready"}, 32'(frame_ready),   32'h0);
      checkOutput({tag, " frame_count"}, 32'(frame_count),   32'h0);
      checkOutput({tag, " addr_error"},  32'(addr_error),    32'h0);
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      preload_en   = 1'b1;
      preload_addr = a;
      preload_data = d;
      @(negedge clk);
      preload_en   = 1'b0;
   endtask

   task automatic startFrame();
      @(negedge clk);
      bus.spi_selected = 1'b1;
      @(negedge clk);
   endtask

   task automatic endFrame();
      @(negedge clk);
      bus.spi_selected = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic sendByte(input logic [7:0] b);
      @(negedge clk);
      bus.spi_dout = b;
      bus.spi_done = 1'b1;
      @(negedge clk);
      bus.spi_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic sendByteFast(input logic [7:0] b);
      @(negedge clk);
      bus.spi_dout = b;
      bus.spi_done = 1'b1;
      @(negedge clk);
      bus.spi_done = 1'b0;
   endtask

   task automatic applyStimulus(input int idx, input vec_t v);
      int    base;
      string tag;
      tag  = $sformatf("vec%0d", idx);
      base = wrAddrQ.size();
      startFrame();
      for (int k = 0; k < v.nBytes; k++) begin
         sendByte(v.bytes[39-8*k -: 8]);
      end
      endFrame();
      checkOutput({tag, " write count"}, 32'(wrAddrQ.size() - base), 32'(v.expWrites));
      if (v.expWrites > 0) begin
         checkOutput({tag, " addr0"}, 32'(wrAddrQ[base]), 32'(v.expAddr0));
         checkOutput({tag, " data0"}, 32'(wrDataQ[base]), 32'(v.expData0));
      end
      if (v.expWrites > 1) begin
         checkOutput({tag, " addr1"}, 32'(wrAddrQ[base+1]), 32'(v.expAddr1));
         checkOutput({tag, " data1"}, 32'(wrDataQ[base+1]), 32'(v.expData1));
      end
      checkOutput({tag, " addr_error"}, 32'(addr_error), 32'(v.expErr));
   endtask

   initial begin
      int base;
      checks   = 0;
      failures = 0;

      vecs[0] = '{5, 40'h01_00_05_AA_BB, 2, 13'd5,   8'hAA, 13'd6, 8'hBB, 1'b0};
      vecs[1] = '{5, 40'h01_01_DF_11_22, 2, 13'd479, 8'h11, 13'd0, 8'h22, 1'b0};
      vecs[2] = '{4, 40'h01_00_64_5A_00, 1, 13'd100, 8'h5A, 13'd0, 8'h00, 1'b0};
      vecs[3] = '{5, 40'h07_01_00_05_AA, 0, 13'd0,   8'h00, 13'd0, 8'h00, 1'b0};
      vecs[4] = '{2, 40'h01_00_00_00_00, 0, 13'd0,   8'h00, 13'd0, 8'h00, 1'b0};
      vecs[5] = '{4, 40'h01_01_E0_55_00, 0, 13'd0,   8'h00, 13'd0, 8'h00, 1'b1};

      rst_n            = 1'b0;
      bus.spi_selected = 1'b0;
      bus.spi_done     = 1'b0;
      bus.spi_dout     = 8'h00;
      preload_en       = 1'b0;
      preload_addr     = '0;
      preload_data     = 8'h00;
      repeat (3) @(negedge clk);
      checkResetOutputs("in reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkResetOutputs("after reset");

      $display("[TB] commit sequence");
      for (int n = 0; n < 3; n++) begin
         startFrame();
         sendByte(8'h03);
         endFrame();
      end
      checkOutput("commit frame_count", 32'(frame_count), 32'd3);
      checkOutput("commit frame_ready cycles", 32'(frameReadyCycles), 32'd3);

      $display("[TB] write vector table");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i, vecs[i]);
      end

      $display("[TB] read sequence");
      preload(13'd10, 8'h3C);
      preload(13'd11, 8'h7E);
      preload(13'd12, 8'h99);
      base = wrAddrQ.size();
      startFrame();
      sendByte(8'h02);
      sendByte(8'h00);
      sendByte(8'h0A);
      checkOutput("read byte0", 32'(bus.spi_din), 32'h3C);
      sendByte(8'h00);
      checkOutput("read byte1", 32'(bus.spi_din), 32'h7E);
      sendByte(8'h00);
      checkOutput("read byte2", 32'(bus.spi_din), 32'h99);
      endFrame();
      checkOutput("read spi_din after deselect", 32'(bus.spi_din), 32'h00);
      checkOutput("read no writes", 32'(wrAddrQ.size() - base), 32'd0);

      $display("[TB] back-to-back write sequence");
      base = wrAddrQ.size();
      startFrame();
      sendByte(8'h01);
      sendByte(8'h00);
      sendByte(8'h14);
      sendByteFast(8'hC1);
      sendByteFast(8'hC2);
      sendByteFast(8'hC3);
      repeat (3) @(negedge clk);
      endFrame();
      checkOutput("b2b write count", 32'(wrAddrQ.size() - base), 32'd3);
      checkOutput("b2b addr0", 32'(wrAddrQ[base]),   32'd20);
      checkOutput("b2b data0", 32'(wrDataQ[base]),   32'hC1);
      checkOutput("b2b addr1", 32'(wrAddrQ[base+1]), 32'd21);
      checkOutput("b2b data1", 32'(wrDataQ[base+1]), 32'hC2);
      checkOutput("b2b addr2", 32'(wrAddrQ[base+2]), 32'd22);
      checkOutput("b2b data2", 32'(wrDataQ[base+2]), 32'hC3);

      $display("[TB] reset during write");
      preload(13'd30, 8'h00);
      startFrame();
      sendByte(8'h01);
      sendByte(8'h00);
      sendByte(8'h1E);
      base = wrAddrQ.size();
      @(negedge clk);
      bus.spi_dout = 8'h77;
      bus.spi_done = 1'b1;
      @(posedge clk);
      #2;
      rst_n        = 1'b0;
      bus.spi_done = 1'b0;
      @(negedge clk);
      checkResetOutputs("mid-write reset");
      bus.spi_selected = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("mid-write reset no write", 32'(wrAddrQ.size() - base), 32'd0);
      checkOutput("mid-write reset mem[30]", 32'(mem[30]), 32'h00);
      checkResetOutputs("held reset deselected");

      $display("[TB] restart with select already high");
      bus.spi_selected = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      base  = wrAddrQ.size();
      sendByte(8'h01);
      sendByte(8'h00);
      sendByte(8'h28);
      sendByte(8'hAB);
      endFrame();
      checkOutput("restart write count", 32'(wrAddrQ.size() - base), 32'd1);
      checkOutput("restart addr", 32'(wrAddrQ[base]), 32'd40);
      checkOutput("restart data", 32'(wrDataQ[base]), 32'hAB);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
